// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between IF and data ports.
// Data wins arbitration; a grant counter bounds how long IF can be starved.
module unified_mem_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int RAM_LAT       = 1,
    parameter int IF_STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(RAM_LAT);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(IF_STARVE_MAX);

    state_t            state;
    state_t            state_nxt;
    logic              owner_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [CNT_W-1:0]  lat_cnt;
    logic [CNT_W-1:0]  starve_cnt;
    logic              grant;
    logic              grant_d;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_d   = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        if_valid  = 1'b0;
        d_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req || if_req) begin
                    grant     = 1'b1;
                    // IF wins only once data has taken its quota of grants
                    grant_d   = d_req && !(if_req && starve_cnt == STARVE_LIM);
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                ram_en    = 1'b1;
                ram_we    = we_q;
                state_nxt = we_q ? RESP : WAIT;
            end
            WAIT: begin
                if (lat_cnt == CNT_W'(1)) state_nxt = RESP;
            end
            RESP: begin
                if_valid  = !owner_d;
                d_valid   = owner_d;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner_d    <= grant_d;
                we_q       <= grant_d && d_we;
                addr_q     <= grant_d ? d_addr : if_addr;
                starve_cnt <= (grant_d && if_req) ? starve_cnt + CNT_W'(1) : '0;
                if (grant_d) wdata_q <= d_wdata;
            end
            if (state == ISSUE) begin
                lat_cnt <= LAT_INIT;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - CNT_W'(1);
                if (lat_cnt == CNT_W'(1)) begin
                    if (owner_d) d_rdata_q <= ram_rdata;
                    else         if_rdata_q <= ram_rdata;
                end
            end
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = if_req & ~if_valid;
    assign d_stall   = d_req & ~d_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: two instances (RAM_LAT 1 and 3), each
// with a latency-modelled RAM, checked against a transaction-level model.
module tb_unified_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst       [2];
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic [31:0] if_rdata  [2];
    logic        if_valid  [2];
    logic        if_stall  [2];
    logic        d_req     [2];
    logic        d_we      [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic [31:0] d_rdata   [2];
    logic        d_valid   [2];
    logic        d_stall   [2];
    logic        ram_en    [2];
    logic        ram_we    [2];
    logic [31:0] ram_addr  [2];
    logic [31:0] ram_wdata [2];
    logic [31:0] ram_rdata [2];

    always #5 clk = ~clk;

    function automatic logic [31:0] seed(input int idx);
        return (idx == 16) ? 32'h2402_000A
                           : (32'h1357_9BDF ^ (32'(idx) * 32'h9E37_79B1));
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int L = (k == 0) ? 1 : 3;
        bit   [31:0] mem  [64];
        bit          wr   [64];
        logic [31:0] pipe [L];

        unified_mem_arbiter #(
            .ADDR_W(32), .DATA_W(32), .RAM_LAT(L), .IF_STARVE_MAX(2)
        ) dut (
            .clk(clk), .rst(rst[k]),
            .if_req(if_req[k]), .if_addr(if_addr[k]),
            .if_rdata(if_rdata[k]), .if_valid(if_valid[k]),
            .if_stall(if_stall[k]),
            .d_req(d_req[k]), .d_we(d_we[k]), .d_addr(d_addr[k]),
            .d_wdata(d_wdata[k]), .d_rdata(d_rdata[k]),
            .d_valid(d_valid[k]), .d_stall(d_stall[k]),
            .ram_en(ram_en[k]), .ram_we(ram_we[k]),
            .ram_addr(ram_addr[k]), .ram_wdata(ram_wdata[k]),
            .ram_rdata(ram_rdata[k])
        );

        assign ram_rdata[k] = pipe[L-1];

        // Unaddressed cycles push noise so a mistimed capture is visible
        always @(posedge clk) begin
            if (ram_en[k] && ram_we[k]) begin
                mem[ram_addr[k][7:2]] <= ram_wdata[k];
                wr[ram_addr[k][7:2]]  <= 1'b1;
            end
            if (ram_en[k] && !ram_we[k])
                pipe[0] <= wr[ram_addr[k][7:2]] ? mem[ram_addr[k][7:2]]
                                                : seed(int'(ram_addr[k][7:2]));
            else
                pipe[0] <= $urandom;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state
    int          cyc, free_cyc, starve, g_cyc, done_cyc;
    bit          have, c_d, c_we;
    logic [31:0] c_addr, c_wdata, c_rd, sh_addr, exp_if_rd, exp_d_rd;
    bit          ev_if, ev_d, e_en, e_we;
    bit   [31:0] mmem [64];
    bit          mw   [64];

    // Requester state
    bit          ia, da, da_we, i_done, d_done;
    logic [31:0] ia_addr, da_addr, da_wdata;

    // Observations from the DUT
    int          n_en, n_ifs, n_ifv, n_dv, en_cyc, we_cyc, ifv_cyc, dv_cyc;
    logic [31:0] ifv_data, dv_data;
    int          vq [$];

    function automatic logic [31:0] mread(input logic [31:0] a);
        return mw[a[7:2]] ? mmem[a[7:2]] : seed(int'(a[7:2]));
    endfunction

    function automatic logic [31:0] raddr();
        return {24'h0, 6'($urandom_range(63)), 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h (cyc %0d)",
                    tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        cyc = 0; free_cyc = 0; starve = 0; have = 0;
        sh_addr = '0; c_wdata = '0; exp_if_rd = '0; exp_d_rd = '0;
        ia = 0; da = 0; i_done = 0; d_done = 0;
    endtask

    task automatic clear_obs();
        n_en = 0; n_ifs = 0; n_ifv = 0; n_dv = 0;
        en_cyc = -1; we_cyc = -1; ifv_cyc = -1; dv_cyc = -1;
        ifv_data = '0; dv_data = '0;
        vq.delete();
    endtask

    task automatic drive(input int k);
        if_req[k]  = ia;
        if_addr[k] = ia ? ia_addr : $urandom;
        d_req[k]   = da;
        d_we[k]    = da ? da_we : 1'($urandom_range(1));
        d_addr[k]  = da ? da_addr : $urandom;
        d_wdata[k] = da ? da_wdata : $urandom;
    endtask

    task automatic model_eval(input int k);
        bit gd;
        int lat;
        lat = (k == 0) ? 1 : 3;
        ev_if = 0; ev_d = 0; e_en = 0; e_we = 0;
        if (have && cyc == g_cyc + 1) begin
            sh_addr = c_addr; e_en = 1; e_we = c_we;
        end
        if (have && cyc == done_cyc) begin
            if (c_d) ev_d = 1; else ev_if = 1;
            if (!c_we) begin
                if (c_d) exp_d_rd = c_rd; else exp_if_rd = c_rd;
            end
        end
        if (cyc >= free_cyc && (ia || da)) begin
            gd     = da && !(ia && starve == 2);
            starve = (gd && ia) ? starve + 1 : 0;
            have   = 1;
            c_d    = gd;
            c_we   = gd && da_we;
            c_addr = gd ? da_addr : ia_addr;
            if (gd) c_wdata = da_wdata;
            g_cyc    = cyc;
            done_cyc = cyc + (c_we ? 2 : 2 + lat);
            free_cyc = done_cyc + 1;
            if (c_we) begin
                mmem[c_addr[7:2]] = c_wdata;
                mw[c_addr[7:2]]   = 1;
            end else begin
                c_rd = mread(c_addr);
            end
        end
    endtask

    task automatic observe(input int k);
        if (ram_en[k]) begin n_en++; if (en_cyc < 0) en_cyc = cyc; end
        if (ram_we[k] && we_cyc < 0) we_cyc = cyc;
        if (if_stall[k]) n_ifs++;
        if (if_valid[k]) begin
            n_ifv++; if (ifv_cyc < 0) ifv_cyc = cyc;
            ifv_data = if_rdata[k]; vq.push_back(0);
        end
        if (d_valid[k]) begin
            n_dv++; if (dv_cyc < 0) dv_cyc = cyc;
            dv_data = d_rdata[k]; vq.push_back(1);
        end
    endtask

    task automatic check(input int k);
        chk("ram_en", 32'(ram_en[k]), 32'(e_en));
        chk("ram_we", 32'(ram_we[k]), 32'(e_we));
        chk("ram_addr", ram_addr[k], sh_addr);
        if (e_we) chk("ram_wdata", ram_wdata[k], c_wdata);
        chk("if_valid", 32'(if_valid[k]), 32'(ev_if));
        chk("d_valid", 32'(d_valid[k]), 32'(ev_d));
        chk("if_rdata", if_rdata[k], exp_if_rd);
        chk("d_rdata", d_rdata[k], exp_d_rd);
        chk("if_stall", 32'(if_stall[k]), 32'(ia && !ev_if));
        chk("d_stall", 32'(d_stall[k]), 32'(da && !ev_d));
        if (ev_if) i_done = 1;
        if (ev_d) d_done = 1;
    endtask

    task automatic step(input int k, input int p, input bit do_rst);
        if (i_done) ia = 0;
        if (d_done) da = 0;
        i_done = 0; d_done = 0;
        if (!ia && $urandom_range(99) < p) begin
            ia = 1; ia_addr = raddr();
        end
        if (!da && $urandom_range(99) < p) begin
            da = 1; da_we = 1'($urandom_range(1));
            da_addr = raddr(); da_wdata = $urandom;
        end
        drive(k);
        @(negedge clk);
        model_eval(k);
        observe(k);
        check(k);
        if (do_rst) rst[k] = 1'b1;
        @(posedge clk); #1;
        cyc++;
        if (do_rst) begin rst[k] = 1'b0; model_reset(); end
    endtask

    task automatic reset_dut(input int k);
        ia = 0; da = 0; drive(k);
        rst[k] = 1'b1;
        @(posedge clk); #1;
        rst[k] = 1'b0;
        model_reset();
    endtask

    initial begin
        bit pat [6];
        pat = '{1, 1, 0, 1, 1, 0};
        for (int i = 0; i < 64; i++) begin mmem[i] = '0; mw[i] = 0; end
        model_reset();
        drive(1);
        rst[1] = 1'b1;
        reset_dut(0);
        reset_dut(1);

        // Reset state, then a lone IF read
        clear_obs();
        step(0, 0, 0);
        ia = 1; ia_addr = 32'h40; cyc = 0;
        repeat (5) step(0, 0, 0);
        chk("t1_en_cyc", en_cyc, 1);
        chk("t1_ifv_cyc", ifv_cyc, 3);
        chk("t1_ifv_data", ifv_data, 32'h2402_000A);
        chk("t1_stall_cycles", n_ifs, 3);

        // Write then read back through the data port
        reset_dut(0); clear_obs();
        da = 1; da_we = 1; da_addr = 32'h10; da_wdata = 32'hDEAD_BEEF;
        repeat (4) step(0, 0, 0);
        chk("t2_we_cyc", we_cyc, 1);
        chk("t2_dv_cyc", dv_cyc, 2);
        da = 1; da_we = 0; da_addr = 32'h10;
        repeat (6) step(0, 0, 0);
        chk("t2_readback", dv_data, 32'hDEAD_BEEF);

        // Simultaneous requests
        reset_dut(0); clear_obs();
        ia = 1; ia_addr = 32'h44;
        da = 1; da_we = 0; da_addr = 32'h10;
        repeat (9) step(0, 0, 0);
        chk("t3_dv_cyc", dv_cyc, 3);
        chk("t3_ifv_cyc", ifv_cyc, 7);
        chk("t3_dv_data", dv_data, 32'hDEAD_BEEF);

        // Starvation bound with both ports always requesting
        reset_dut(0); clear_obs();
        for (int n = 0; n < 60 && vq.size() < 6; n++) step(0, 100, 0);
        chk("t4_grants", vq.size() >= 6, 1);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t4_order%0d", i),
                (i < vq.size()) ? vq[i] : 32'hFFFF_FFFF, 32'(pat[i]));

        // Reset in the middle of an IF read
        reset_dut(0); clear_obs();
        ia = 1; ia_addr = 32'h48;
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        repeat (2) step(0, 0, 0);
        chk("t6_no_valid", n_ifv, 0);
        clear_obs();
        ia = 1; ia_addr = 32'h40; cyc = 0;
        repeat (5) step(0, 0, 0);
        chk("t6_en_cyc", en_cyc, 1);
        chk("t6_ifv_cyc", ifv_cyc, 3);
        chk("t6_ifv_data", ifv_data, mread(32'h40));

        // Randomised traffic, RAM_LAT = 1
        reset_dut(0);
        repeat (400) step(0, 40, 0);
        reset_dut(0);

        // RAM_LAT = 3 instance
        for (int i = 0; i < 64; i++) begin mmem[i] = '0; mw[i] = 0; end
        reset_dut(1); clear_obs();
        da = 1; da_we = 0; da_addr = 32'h20;
        repeat (8) step(1, 0, 0);
        chk("t5_en_count", n_en, 1);
        chk("t5_en_cyc", en_cyc, 1);
        chk("t5_dv_cyc", dv_cyc, 5);
        chk("t5_dv_data", dv_data, mread(32'h20));
        chk("t5_valid_count", n_dv + n_ifv, 1);
        reset_dut(1);
        repeat (300) step(1, 40, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
